dcache_store_buffer: RTL

//  Commit-side store FIFO that drives the store request port of the non-blocking L1 dcache.
//  - Accepts committed stores by physical address and replays them into the cache controller.
//  - Uses the two-phase index/tag dcache_req protocol: index+data first, tag on the next cycle.
//  - Flags load/store page-offset conflicts so the load unit can stall.

---
 rtl/dcache_store_buffer_if.sv | 38 +++
 rtl/dcache_store_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dcache_store_buffer_if.sv
// Store-port bundle between the store buffer and the L1 dcache controller.
//
// Handshake: the master raises data_req together with address_index,
// data_wdata, data_be, data_size and data_we, and holds all of them stable
// until the slave answers with data_gnt. The request is accepted on the cycle
// data_req && data_gnt are both high. On the following cycle the master
// presents tag_valid with address_tag for that same request. kill_req is
// never used by the store path. data_rvalid/data_rdata carry load responses
// only and are ignored by a store master.
interface dcache_store_buffer_if #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
);
    logic [INDEX_W-1:0] address_index;
    logic [TAG_W-1:0]   address_tag;
    logic [63:0]        data_wdata;
    logic               data_req;
    logic               data_we;
    logic [7:0]         data_be;
    logic [1:0]         data_size;
    logic               kill_req;
    logic               tag_valid;
    logic               data_gnt;
    logic               data_rvalid;
    logic [63:0]        data_rdata;

    modport master (
        output address_index, address_tag, data_wdata, data_req, data_we,
               data_be, data_size, kill_req, tag_valid,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  address_index, address_tag, data_wdata, data_req, data_we,
               data_be, data_size, kill_req, tag_valid,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/dcache_store_buffer.sv
// Commit-side store FIFO feeding the dcache store port with the two-phase
// index/tag protocol, plus a page-offset conflict flag for the load unit.
// Optional feature macro: DCACHE_STB_FULL_CNT_EN adds full_cycles_o, a
// saturating count of cycles spent with the buffer full.
module dcache_store_buffer #(
    parameter int DEPTH   = 4,
    parameter int PADDR_W = 56
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         st_valid_i,
    output logic                         st_ready_o,
    input  logic [PADDR_W-1:0]           st_paddr_i,
    input  logic [63:0]                  st_data_i,
    input  logic [7:0]                   st_be_i,
    input  logic [1:0]                   st_size_i,
    input  logic [11:0]                  ld_paddr_i,
    output logic                         ld_conflict_o,
    output logic                         empty_o,
    output logic                         dbg_state_o,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o,
`ifdef DCACHE_STB_FULL_CNT_EN
    output logic [31:0]                  full_cycles_o,
`endif
    dcache_store_buffer_if.master        req_port
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int INDEX_W = 12;
    localparam int TAG_W   = PADDR_W - INDEX_W;

    typedef enum logic {
        IDLE     = 1'b0,
        SEND_TAG = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push, pop;

    logic [PADDR_W-1:0] mem_paddr [DEPTH];
    logic [63:0]        mem_data  [DEPTH];
    logic [7:0]         mem_be    [DEPTH];
    logic [1:0]         mem_size  [DEPTH];

    logic [PADDR_W-1:0] head_paddr;
    logic               unused_rsp;

    assign head_paddr  = mem_paddr[rd_ptr_q];
    assign st_ready_o  = (count_q != CNT_W'(DEPTH));
    assign push        = st_valid_i && st_ready_o;
    assign empty_o     = (count_q == '0) && (state_q == IDLE);
    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;
    assign unused_rsp  = ^{req_port.data_rvalid, req_port.data_rdata, ld_paddr_i[2:0]};

    // Entry storage: written on push only, validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_paddr[wr_ptr_q] <= st_paddr_i;
            mem_data[wr_ptr_q]  <= st_data_i;
            mem_be[wr_ptr_q]    <= st_be_i;
            mem_size[wr_ptr_q]  <= st_size_i;
        end
    end

    // Pointers, occupancy and FSM state; reset drops every buffered entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Request FSM: index/data phase held until grant, then one tag cycle that pops the head
    always_comb begin
        state_d                = state_q;
        pop                    = 1'b0;
        req_port.address_index = '0;
        req_port.address_tag   = '0;
        req_port.data_wdata    = '0;
        req_port.data_req      = 1'b0;
        req_port.data_we       = 1'b0;
        req_port.data_be       = '0;
        req_port.data_size     = '0;
        req_port.kill_req      = 1'b0;
        req_port.tag_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    req_port.data_req      = 1'b1;
                    req_port.data_we       = 1'b1;
                    req_port.address_index = head_paddr[INDEX_W-1:0];
                    req_port.data_wdata    = mem_data[rd_ptr_q];
                    req_port.data_be       = mem_be[rd_ptr_q];
                    req_port.data_size     = mem_size[rd_ptr_q];
                    if (req_port.data_gnt) state_d = SEND_TAG;
                end
            end
            SEND_TAG: begin
                req_port.tag_valid   = 1'b1;
                req_port.address_tag = head_paddr[PADDR_W-1:INDEX_W];
                pop                  = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load conflict: any live entry (head included until popped) in the same 64-bit word
    always_comb begin
        logic [PTR_W-1:0] offs;
        ld_conflict_o = 1'b0;
        offs          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr_q;
            if ((CNT_W'(offs) < count_q) && (mem_paddr[i][11:3] == ld_paddr_i[11:3]))
                ld_conflict_o = 1'b1;
        end
    end

`ifdef DCACHE_STB_FULL_CNT_EN
    logic [31:0] full_cycles_q;
    assign full_cycles_o = full_cycles_q;

    // Saturating count of cycles spent with every entry occupied
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_cycles_q <= '0;
        end else if ((count_q == CNT_W'(DEPTH)) && (full_cycles_q != 32'hFFFF_FFFF)) begin
            full_cycles_q <= full_cycles_q + 32'd1;
        end
    end
`endif

endmodule
